// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for serial_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b,
`ifdef SERIAL_SUB_OVF_EN
        input  ovf,
`endif
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
`ifdef SERIAL_SUB_OVF_EN
        output ovf,
`endif
        output busy, done, diff, borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell plus a borrow flop.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   sub_if
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sb_q, part_q, diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q, borrow_q, done_q;

    logic             ai, bi, d, brNext, lastBit;
    logic [WIDTH-1:0] partNext;

    assign ai       = sa_q[0];
    assign bi       = sb_q[0];
    assign d        = ai ^ bi ^ br_q;
    assign brNext   = (~ai & bi) | (~(ai ^ bi) & br_q);
    assign partNext = {d, part_q[WIDTH-1:1]};
    assign lastBit  = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_OVF_EN
    logic aSign_q, bSign_q, ovf_q, ovfNext;

    // The final d is the result's sign bit, so overflow is decided on the done edge.
    assign ovfNext = (aSign_q != bSign_q) && (d != aSign_q);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sub_if.start) state_d = RUN;
            RUN:     if (lastBit)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sub_if.busy = (state_q == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_q     <= '0;
            sb_q     <= '0;
            part_q   <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            aSign_q  <= 1'b0;
            bSign_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (sub_if.start) begin
                    sa_q   <= sub_if.a;
                    sb_q   <= sub_if.b;
                    part_q <= '0;
                    cnt_q  <= '0;
                    br_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                    aSign_q <= sub_if.a[WIDTH-1];
                    bSign_q <= sub_if.b[WIDTH-1];
`endif
                end
            end else begin
                sa_q   <= sa_q >> 1;
                sb_q   <= sb_q >> 1;
                part_q <= partNext;
                br_q   <= brNext;
                cnt_q  <= cnt_q + CW'(1);
                // Visible results move only here so they hold steady through RUN.
                if (lastBit) begin
                    diff_q   <= partNext;
                    borrow_q <= brNext;
                    done_q   <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_q    <= ovfNext;
`endif
                end
            end
        end
    end

    assign sub_if.done   = done_q;
    assign sub_if.diff   = diff_q;
    assign sub_if.borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign sub_if.ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed scenarios plus random operands against an arithmetic model.
// Checks ovf as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] prevDiff;
    logic         prevBorrow;
    logic         prevOvf;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .sub_if (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    // Reference: plain modular arithmetic, unsigned compare, and signed range test.
    task automatic modelSub(input logic [W-1:0] av, input logic [W-1:0] bv,
                            output logic [W-1:0] dv, output logic brv, output logic ov);
        int sa, sb, r;
        dv  = W'((int'(av) - int'(bv)) & ((1 << W) - 1));
        brv = (av < bv);
        sa  = av[W-1] ? int'(av) - (1 << W) : int'(av);
        sb  = bv[W-1] ? int'(bv) - (1 << W) : int'(bv);
        r   = sa - sb;
        ov  = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResult(input string tag, input logic [W-1:0] dv, input logic brv,
                               input logic ov);
        checkOutput({tag, " diff"}, 32'(bus.diff), 32'(dv));
        checkOutput({tag, " borrow"}, 32'(bus.borrow), 32'(brv));
`ifdef SERIAL_SUB_OVF_EN
        checkOutput({tag, " ovf"}, 32'(bus.ovf), 32'(ov));
`endif
        if (ov === 1'bx) $display("[TB] unreachable");
    endtask

    // Runs one full operation from IDLE and checks every cycle of it.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
        logic [W-1:0] expDiff;
        logic         expBorrow, expOvf;
        modelSub(av, bv, expDiff, expBorrow, expOvf);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        checkOutput({tag, " busy@E0"}, 32'(bus.busy), 32'd1);
        for (int k = 1; k <= W; k++) begin
            @(posedge clk); #1;
            if (k < W) begin
                checkOutput({tag, " busy mid"}, 32'(bus.busy), 32'd1);
                checkOutput({tag, " done mid"}, 32'(bus.done), 32'd0);
                checkResult({tag, " held"}, prevDiff, prevBorrow, prevOvf);
            end
        end
        checkOutput({tag, " done@EW"}, 32'(bus.done), 32'd1);
        checkOutput({tag, " busy@EW"}, 32'(bus.busy), 32'd0);
        checkResult(tag, expDiff, expBorrow, expOvf);
        prevDiff   = expDiff;
        prevBorrow = expBorrow;
        prevOvf    = expOvf;
        @(posedge clk); #1;
        checkOutput({tag, " done pulse"}, 32'(bus.done), 32'd0);
        checkOutput({tag, " idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        prevDiff   = '0;
        prevBorrow = 1'b0;
        prevOvf    = 1'b0;

        #2;
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkResult("reset", '0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(8'h5A, 8'h3C, "5A-3C");
        applyStimulus(8'h10, 8'h20, "10-20");
        applyStimulus(8'h80, 8'h01, "80-01");

        // Second start during RUN must be ignored, operands stay as captured.
        bus.start = 1'b1; bus.a = 8'h05; bus.b = 8'h03;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= W; k++) begin
            if (k == 3) begin
                bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h00;
            end
            @(posedge clk); #1;
            if (k == 4) bus.start = 1'b0;
            if (k < W) checkResult("ignore held", prevDiff, prevBorrow, prevOvf);
        end
        checkOutput("ignore done", 32'(bus.done), 32'd1);
        checkResult("ignore", 8'h02, 1'b0, 1'b0);
        prevDiff = 8'h02; prevBorrow = 1'b0; prevOvf = 1'b0;
        @(posedge clk); #1;
        checkOutput("ignore no restart", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of a run.
        bus.start = 1'b1; bus.a = 8'h37; bus.b = 8'h11;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("async rst busy", 32'(bus.busy), 32'd0);
        checkOutput("async rst done", 32'(bus.done), 32'd0);
        checkResult("async rst", '0, 1'b0, 1'b0);
        prevDiff = '0; prevBorrow = 1'b0; prevOvf = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(8'h09, 8'h09, "09-09");

        // start held high: back-to-back acceptance right after done.
        bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
        @(posedge clk); #1;
        for (int k = 1; k <= 2 * W + 1; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("b2b done E%0d", k), 32'(bus.done),
                        32'((k == W) || (k == 2 * W + 1)));
            checkOutput($sformatf("b2b busy E%0d", k), 32'(bus.busy),
                        32'((k < W) || (k > W && k <= 2 * W)));
            if (k == W + 1) bus.start = 1'b0;
        end
        checkResult("b2b", 8'h00, 1'b0, 1'b0);
        prevDiff = '0; prevBorrow = 1'b0; prevOvf = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 16; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            applyStimulus(ra, rb, $sformatf("rand%0d %02h-%02h", n, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion to the team's adder cells. It sits next to the adder cells for area-constrained datapaths where latency is acceptable, and uses a start/busy/done handshake.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range is WIDTH >= 2.

Ports:
- `clk` input, 1 bit: single clock, rising-edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: request to begin a subtraction; sampled only in IDLE.
- `a` input, WIDTH bits: minuend, captured on the accepted start edge.
- `b` input, WIDTH bits: subtrahend, captured on the accepted start edge.
- `busy` output, 1 bit: high while an operation is in progress.
- `done` output, 1 bit: one-cycle pulse marking that the result is valid.
- `diff` output, WIDTH bits: result `(a - b) mod 2^WIDTH`; held until the next done.
- `borrow` output, 1 bit: unsigned borrow-out, 1 when a < b; held with `diff`.
- `ovf` output, 1 bit: signed overflow; present only when `SERIAL_SUB_OVF_EN` is defined.

## Operation
- State machine states:
  - IDLE: `busy` = 0. If `start` = 1 at an edge:
    - latch `a` and `b` into shift registers;
    - clear the borrow flip-flop and bit counter;
    - go to RUN.
  - RUN: each edge does all of the following, then increments the counter:
    - take `ai` = sa[0] and `bi` = sb[0];
    - compute d = ai ^ bi ^ br;
    - compute br_next = (~ai & bi) | (~(ai ^ bi) & br);
    - shift d into the MSB of the partial-difference register;
    - shift sa and sb right by one bit.
  - RUN to IDLE: on the edge that processes bit WIDTH-1:
    - copy the completed partial difference into `diff`;
    - copy br_next into `borrow`;
    - pulse `done`;
    - return to IDLE.
- Counter width is $clog2(WIDTH). All arithmetic is modulo 2^WIDTH; there are no sign extensions.
- `start` while busy: ignored. Operands captured at acceptance are used, and later changes to `a`/`b` have no effect.
- `diff`, `borrow` and `ovf` change only on the done edge. They stay stable during RUN, still showing the previous result.
- Reset at any time, including mid-RUN: the following clear immediately, without waiting for a clock edge:
  - state → IDLE;
  - `busy`, `done`, `diff`, `borrow`, `ovf` → 0;
  - internal registers → 0.
- Reset values of every output: 0.

## Timing
- Acceptance edge E0: `start` = 1 in IDLE; `busy` becomes 1 after E0.
- Edges E1..EWIDTH each process one bit.
- At EWIDTH: `done` = 1 for exactly one cycle, results update, and `busy` = 0.
- Latency: WIDTH cycles from the acceptance edge to `done`. Throughput is one operation per WIDTH+1 cycles.
- Back-to-back: `start` held high during the `done` cycle is accepted at EWIDTH+1.
- `done` and `busy` are never both 1.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - the `ovf` port exists;
  - on the done edge, ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), using the latched operand sign bits;
  - reset value is 0;
  - `ovf` is held with `diff`.
- Not defined: no `ovf` port, no sign-bit storage, and otherwise identical behaviour.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, pulse `start`:
  - `busy` is high for 8 cycles;
  - `done` is a 1-cycle pulse at E8;
  - diff=0x1E, borrow=0, ovf=0.
- a=0x10, b=0x20: diff=0xF0, borrow=1, ovf=0.
- a=0x80, b=0x01: diff=0x7F, borrow=0, ovf=1 (macro defined). With the macro undefined, the design compiles without `ovf`.
- Start a=0x05, b=0x03; at E3 drive a=0xFF, b=0x00 and pulse `start` again:
  - the second request is ignored;
  - diff=0x02 at E8;
  - `diff` holds the prior value during E1..E7.
- Start an operation, then assert `rst` asynchronously mid-cycle after E4:
  - all outputs are 0 before the next edge;
  - after release, a=0x09, b=0x09 gives diff=0x00, borrow=0 at done.
- a=b=0xFF with `start` held continuously:
  - diff=0x00, borrow=0;
  - second acceptance at E9, with the second `done` at E17.
